// File: rtl/weighted_two_layer_snn.sv
// Two-layer leaky integrate-and-fire network: N_IN hidden neurons fed by input currents,
// N_OUT output neurons fed through a signed weight matrix, one time step per handshake.
module weighted_two_layer_snn #(
    parameter int N_IN       = 4,
    parameter int N_OUT      = 3,
    parameter int DW         = 8,
    parameter int WW         = 8,
    parameter int VW         = 10,
    parameter int THRESH     = 100,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRAC     = 2,
    parameter int DEFAULT_W  = 10
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [N_IN-1:0][DW-1:0]                   input_current,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [N_OUT-1:0]                          spike_out,
    input  logic                                      w_we,
    input  logic [((N_IN > 1) ? $clog2(N_IN) : 1)-1:0] w_hid,
    input  logic [((N_OUT > 1) ? $clog2(N_OUT) : 1)-1:0] w_out,
    input  logic signed [WW-1:0]                      w_data
);
    localparam int HW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam int AW = WW + HW + 1;
    localparam int SW = VW + DW + 1;

    typedef enum logic [2:0] {S_IDLE, S_L1, S_ACC, S_L2, S_OUT} state_t;

    typedef struct packed {
        logic [VW-1:0] v;
        logic [RW-1:0] r;
        logic          s;
    } nrn_t;

    state_t                 state_q, state_d;
    logic [HW-1:0]          k_q, k_d;
    logic [N_IN-1:0][DW-1:0] cur_q, cur_d;
    logic [N_IN-1:0]        hspk_q, hspk_d;
    logic [N_OUT-1:0]       spk_q, spk_d;
    logic [VW-1:0]          v1_q [N_IN];
    logic [VW-1:0]          v1_d [N_IN];
    logic [RW-1:0]          r1_q [N_IN];
    logic [RW-1:0]          r1_d [N_IN];
    logic [VW-1:0]          v2_q [N_OUT];
    logic [VW-1:0]          v2_d [N_OUT];
    logic [RW-1:0]          r2_q [N_OUT];
    logic [RW-1:0]          r2_d [N_OUT];
    logic signed [AW-1:0]   acc_q [N_OUT];
    logic signed [AW-1:0]   acc_d [N_OUT];
    logic signed [WW-1:0]   w_q [N_OUT][N_IN];
    logic signed [WW-1:0]   w_d [N_OUT][N_IN];

    function automatic logic [VW-1:0] sat_v(input logic [SW-1:0] sum);
        if (sum[SW-1:VW] != '0) return '1;
        return sum[VW-1:0];
    endfunction

    function automatic logic [DW-1:0] clamp_cur(input logic signed [AW-1:0] a);
        int ai;
        ai = int'(a);
        if (ai < 0) return '0;
        if (ai > (1 << DW) - 1) return '1;
        return DW'(ai);
    endfunction

    // Refractory neurons sit at zero; otherwise leak, integrate, saturate, then fire/reset.
    function automatic nrn_t neuron_step(input logic [VW-1:0] v, input logic [RW-1:0] r,
                                         input logic [DW-1:0] cur);
        nrn_t          o;
        logic [VW-1:0] vn;
        o = '0;
        if (r != '0) begin
            o.r = r - 1'b1;
        end else begin
            vn = sat_v(SW'(v) - SW'(v >> LEAK_SHIFT) + SW'(cur));
            if (int'(vn) >= THRESH) begin
                o.s = 1'b1;
                o.r = RW'(REFRAC);
            end else begin
                o.v = vn;
            end
        end
        return o;
    endfunction

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign spike_out = out_valid ? spk_q : '0;

    always_comb begin
        nrn_t n;
        n       = '0;
        state_d = state_q;
        k_d     = k_q;
        cur_d   = cur_q;
        hspk_d  = hspk_q;
        spk_d   = spk_q;
        v1_d    = v1_q;
        r1_d    = r1_q;
        v2_d    = v2_q;
        r2_d    = r2_q;
        acc_d   = acc_q;
        w_d     = w_q;
        case (state_q)
            S_IDLE: begin
                if (w_we && int'(w_hid) < N_IN && int'(w_out) < N_OUT)
                    w_d[w_out][w_hid] = w_data;
                if (in_valid) begin
                    cur_d   = input_current;
                    state_d = S_L1;
                end
            end
            S_L1: begin
                for (int i = 0; i < N_IN; i++) begin
                    n         = neuron_step(v1_q[i], r1_q[i], cur_q[i]);
                    v1_d[i]   = n.v;
                    r1_d[i]   = n.r;
                    hspk_d[i] = n.s;
                end
                for (int j = 0; j < N_OUT; j++) acc_d[j] = '0;
                k_d     = '0;
                state_d = S_ACC;
            end
            // One hidden neuron per cycle is folded into every output accumulator.
            S_ACC: begin
                for (int j = 0; j < N_OUT; j++)
                    if (hspk_q[k_q]) acc_d[j] = acc_q[j] + AW'(w_q[j][k_q]);
                if (int'(k_q) == N_IN - 1) state_d = S_L2;
                else k_d = k_q + 1'b1;
            end
            S_L2: begin
                for (int j = 0; j < N_OUT; j++) begin
                    n        = neuron_step(v2_q[j], r2_q[j], clamp_cur(acc_q[j]));
                    v2_d[j]  = n.v;
                    r2_d[j]  = n.r;
                    spk_d[j] = n.s;
                end
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            cur_q   <= '0;
            hspk_q  <= '0;
            spk_q   <= '0;
            for (int i = 0; i < N_IN; i++) begin
                v1_q[i] <= '0;
                r1_q[i] <= '0;
            end
            for (int j = 0; j < N_OUT; j++) begin
                v2_q[j]  <= '0;
                r2_q[j]  <= '0;
                acc_q[j] <= '0;
                for (int i = 0; i < N_IN; i++) w_q[j][i] <= WW'(DEFAULT_W);
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cur_q   <= cur_d;
            hspk_q  <= hspk_d;
            spk_q   <= spk_d;
            v1_q    <= v1_d;
            r1_q    <= r1_d;
            v2_q    <= v2_d;
            r2_q    <= r2_d;
            acc_q   <= acc_d;
            w_q     <= w_d;
        end
    end
endmodule

// File: tb/tb_weighted_two_layer_snn.sv
// Bench for weighted_two_layer_snn: directed scenarios plus randomized time steps
// checked against an integer model of the two neuron layers.
module tb_weighted_two_layer_snn;
    localparam int N_IN = 4, N_OUT = 3, THRESH = 100, LS = 3, REFRAC = 2, VMAX = 1023;

    logic                   clk = 1'b0, reset = 1'b0;
    logic                   in_valid = 1'b0, out_ready = 1'b0, w_we = 1'b0;
    logic                   in_ready, out_valid;
    logic [N_IN-1:0][7:0]   input_current = '0;
    logic [N_OUT-1:0]       spike_out;
    logic [1:0]             w_hid = '0, w_out = '0;
    logic signed [7:0]      w_data = '0;

    int checks = 0, errors = 0;
    logic [N_OUT-1:0] exp_spk = '0;
    int mw [N_OUT][N_IN];
    int mv1 [N_IN], mr1 [N_IN], mv2 [N_OUT], mr2 [N_OUT];
    logic [N_IN-1:0] mhs;
    logic [N_IN-1:0][7:0] all200;

    always #5 clk = ~clk;

    weighted_two_layer_snn dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .input_current(input_current), .out_valid(out_valid), .out_ready(out_ready),
        .spike_out(spike_out), .w_we(w_we), .w_hid(w_hid), .w_out(w_out), .w_data(w_data)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N_IN; i++) begin mv1[i] = 0; mr1[i] = 0; end
        for (int j = 0; j < N_OUT; j++) begin
            mv2[j] = 0; mr2[j] = 0;
            for (int i = 0; i < N_IN; i++) mw[j][i] = 10;
        end
    endfunction

    function automatic bit nstep(inout int v, inout int r, input int cur);
        int vn;
        if (r > 0) begin
            r = r - 1; v = 0;
            return 1'b0;
        end
        vn = v - (v >> LS) + cur;
        if (vn > VMAX) vn = VMAX;
        if (vn >= THRESH) begin
            v = 0; r = REFRAC;
            return 1'b1;
        end
        v = vn;
        return 1'b0;
    endfunction

    function automatic logic [N_OUT-1:0] model_step(input logic [N_IN-1:0][7:0] cur);
        logic [N_OUT-1:0] s;
        int acc;
        s = '0;
        for (int i = 0; i < N_IN; i++) mhs[i] = nstep(mv1[i], mr1[i], int'(cur[i]));
        for (int j = 0; j < N_OUT; j++) begin
            acc = 0;
            for (int i = 0; i < N_IN; i++) if (mhs[i]) acc += mw[j][i];
            if (acc < 0) acc = 0;
            if (acc > 255) acc = 255;
            s[j] = nstep(mv2[j], mr2[j], acc);
        end
        return s;
    endfunction

    task automatic wr(input int hid, input int wo, input int wd);
        w_we = 1'b1; w_hid = 2'(hid); w_out = 2'(wo); w_data = 8'(wd);
        @(posedge clk); #1;
        w_we = 1'b0;
        if (hid < N_IN && wo < N_OUT) mw[wo][hid] = wd;
    endtask

    task automatic wr_all(input int wd);
        for (int j = 0; j < N_OUT; j++)
            for (int i = 0; i < N_IN; i++) wr(i, j, wd);
    endtask

    task automatic run_step(input logic [N_IN-1:0][7:0] cur, input int hold,
                            input bit same_w, input int hid, input int wo, input int wd);
        int lat;
        if (same_w) begin
            w_we = 1'b1; w_hid = 2'(hid); w_out = 2'(wo); w_data = 8'(wd);
            if (hid < N_IN && wo < N_OUT) mw[wo][hid] = wd;
        end
        exp_spk = model_step(cur);
        input_current = cur;
        in_valid = 1'b1;
        check("in_ready_idle", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0; w_we = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, N_IN + 3);
        for (int h = 0; h < hold; h++) begin
            w_we = 1'b1;
            w_hid = 2'($urandom_range(0, 3));
            w_out = 2'($urandom_range(0, 2));
            w_data = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
            w_we = 1'b0;
            check("hold_valid", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("released", int'(out_valid), 0);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (out_valid) begin
                check("spike_out", int'(spike_out), int'(exp_spk));
                check("in_ready_busy", int'(in_ready), 0);
            end else begin
                check("spike_idle", int'(spike_out), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        logic [N_IN-1:0][7:0] rc;
        all200 = {N_IN{8'd200}};
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_spike", int'(spike_out), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_rst", int'(in_ready), 1);

        // default weights: hidden all fire, output integrates 40
        run_step(all200, 0, 1'b0, 0, 0, 0);
        check("pin_s1_hid", int'(mhs), 15);
        check("pin_s1_spk", int'(exp_spk), 0);
        check("pin_s1_v", mv2[0], 40);
        run_step(all200, 0, 1'b0, 0, 0, 0);
        check("pin_s2_hid", int'(mhs), 0);
        check("pin_s2_v", mv2[0], 35);
        run_step(all200, 0, 1'b0, 0, 0, 0);
        check("pin_s3_hid", int'(mhs), 0);
        check("pin_s3_v", mv2[0], 31);

        // strong weights saturate the output current
        wr_all(127);
        run_step(all200, 0, 1'b0, 0, 0, 0);
        check("pin_s4_hid", int'(mhs), 15);
        check("pin_s4_spk", int'(exp_spk), 7);

        // negative weights clamp current to zero
        wr_all(-50);
        run_step(all200, 0, 1'b0, 0, 0, 0);
        run_step(all200, 0, 1'b0, 0, 0, 0);
        run_step(all200, 0, 1'b0, 0, 0, 0);
        check("pin_s7_hid", int'(mhs), 15);
        check("pin_s7_spk", int'(exp_spk), 0);
        check("pin_s7_v", mv2[0], 0);

        // back-pressure with ignored weight writes
        wr_all(60);
        run_step(all200, 5, 1'b0, 0, 0, 0);

        // reset during ACC abandons the step
        input_current = all200;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_spike", int'(spike_out), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_out", int'(seen), 0);
        run_step(all200, 0, 1'b0, 0, 0, 0);
        check("pin_r1_spk", int'(exp_spk), 0);
        check("pin_r1_v", mv2[0], 40);

        for (int s = 0; s < 40; s++) begin
            for (int k = 0; k < int'($urandom_range(0, 2)); k++)
                wr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 227)) - 100);
            for (int i = 0; i < N_IN; i++) rc[i] = 8'($urandom_range(0, 255));
            run_step(rc, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 227)) - 100);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
